pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter RW, default 5: register-address width.
REQ-002 Parameter MULDIV_LAT, default 4, legal 2..16: EX-stage multi-cycle op latency in cycles.
REQ-003 Parameter MEM_TIMEOUT, default 255, legal 1..65535: maximum memory/MMIO wait cycles before trap.
REQ-004 Parameter FWD_EN, default 1: 1 = forwarding enabled, 0 = resolve RAW hazards by stalling.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 id_rs1, id_rs2  in  RW  IF/ID source registers.
REQ-009 ex_rs1, ex_rs2, ex_rd  in  RW  ID/EX source/destination registers.
REQ-010 ex_mem_read, ex_reg_write, ex_muldiv  in  1  ID/EX load, writeback, multi-cycle-op flags.
REQ-011 mem_rd  in  RW; mem_reg_write  in  1  EX/MEM writer.
REQ-012 wb_rd  in  RW; wb_reg_write  in  1  MEM/WB writer.
REQ-013 can_branch, branch_taken, jump  in  1  EX-stage control-flow resolution.
REQ-014 mem_req  in  1  MEM-stage access active; mem_ready  in  1  access completes this cycle.
REQ-015 stall_front  out  1  hold PC and IF/ID.
REQ-016 bubble_id_ex  out  1  load NOP into ID/EX.
REQ-017 flush_if_id  out  1  invalidate IF/ID.
REQ-018 freeze_all  out  1  hold every pipeline register.
REQ-019 pc_sel  out  2  00 PC+4, 01 branch, 10 jump, 11 trap vector.
REQ-020 fwd_a, fwd_b  out  2  EX operand source: 00 regfile, 01 MEM/WB, 10 EX/MEM.
REQ-021 timeout_err  out  1  one-cycle pulse on memory timeout.
REQ-022 state  out  2  00 RUN, 01 MD_WAIT, 10 MEM_WAIT, 11 TRAP.

Function
REQ-023 Forwarding combinational: fwd_a=10 if mem_reg_write, mem_rd!=0, mem_rd==ex_rs1; else 01 if wb_reg_write, wb_rd!=0, wb_rd==ex_rs1; else 00; fwd_b same with ex_rs2; FWD_EN=0 forces 00.
REQ-024 Load-use: in RUN, ex_mem_read, ex_rd!=0, ex_rd matches id_rs1 or id_rs2 -> stall_front=1, bubble_id_ex=1 that cycle only.
REQ-025 FWD_EN=0: in RUN, any writer in EX (ex_reg_write) or MEM (mem_reg_write) with nonzero rd matching id_rs1/id_rs2 -> stall_front=1, bubble_id_ex=1.
REQ-026 Memory wait: in RUN or MD_WAIT-exit, mem_req && !mem_ready -> freeze_all=1 combinationally, next state MEM_WAIT, wait counter cleared to 1.
REQ-027 MEM_WAIT: freeze_all=1 while !mem_ready; counter increments per cycle; mem_ready -> freeze_all=0 that cycle, next RUN.
REQ-028 Counter reaching MEM_TIMEOUT with !mem_ready -> next TRAP; TRAP lasts exactly one cycle: timeout_err=1, pc_sel=11, flush_if_id=1, bubble_id_ex=1, freeze_all=0; then RUN.
REQ-029 Multi-cycle op: ex_muldiv seen in RUN with no memory wait -> freeze_all=1 for exactly MULDIV_LAT-1 consecutive cycles starting that cycle (state MD_WAIT after the first); then RUN with freeze_all=0 so the op advances.
REQ-030 Branch/jump: in RUN, not frozen, jump -> pc_sel=10; else can_branch&&branch_taken -> pc_sel=01; either -> flush_if_id=1, bubble_id_ex=1, stall_front=0.
REQ-031 Priority: TRAP > memory wait > multi-cycle wait > branch/jump > RAW/load-use stall; a taken branch suppresses load-use stall (wrong-path instruction flushed).
REQ-032 stall_front=1 whenever freeze_all=1; while freeze_all=1, flush_if_id=0, bubble_id_ex=0, pc_sel=00.
REQ-033 mem_req and ex_muldiv together in RUN: memory wait first; multi-cycle wait starts the cycle after mem_ready (ex_muldiv still held).
REQ-034 mem_ready asserted with mem_req in RUN: no freeze, state stays RUN.

Reset
REQ-035 rst=1 -> state RUN, counters 0 immediately; outputs stall_front, bubble_id_ex, flush_if_id, freeze_all, timeout_err=0, pc_sel=00, fwd_a=fwd_b=00 while rst held.
REQ-036 Reset mid-MD_WAIT/MEM_WAIT/TRAP aborts the wait; first cycle after release is RUN with no residual freeze or trap pulse.

Verification
REQ-037 ex_mem_read=1, ex_rd=5, id_rs2=5 -> stall_front=1, bubble_id_ex=1 one cycle; ex_rd=0 -> no stall.
REQ-038 mem_rd=3, wb_rd=3 both writing, ex_rs1=3 -> fwd_a=10; mem_reg_write=0 -> fwd_a=01; FWD_EN=0 -> 00 plus stall.
REQ-039 MULDIV_LAT=4, ex_muldiv pulse in RUN -> freeze_all high exactly 3 cycles, then RUN.
REQ-040 MEM_TIMEOUT=8, mem_req=1, mem_ready never -> freeze 8 cycles, then one-cycle timeout_err=1, pc_sel=11; mem_ready at cycle 3 -> no trap.
REQ-041 jump=1 and load-use hazard same cycle -> pc_sel=10, flush_if_id=1, stall_front=0; branch during MEM_WAIT -> pc_sel=00.
REQ-042 rst asserted during MEM_WAIT cycle 4 -> outputs zero immediately; after release, state=00, no timeout_err.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module   : pipeline_hazard_ctrl_if
// Brief    : Pipeline-register fields in, stall/flush/forward controls out.
// Revision : 1.0
//==============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int RW = 5
);
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic [RW-1:0] ex_rs1;
    logic [RW-1:0] ex_rs2;
    logic [RW-1:0] ex_rd;
    logic          ex_mem_read;
    logic          ex_reg_write;
    logic          ex_muldiv;
    logic [RW-1:0] mem_rd;
    logic          mem_reg_write;
    logic [RW-1:0] wb_rd;
    logic          wb_reg_write;
    logic          can_branch;
    logic          branch_taken;
    logic          jump;
    logic          mem_req;
    logic          mem_ready;

    logic          stall_front;
    logic          bubble_id_ex;
    logic          flush_if_id;
    logic          freeze_all;
    logic [1:0]    pc_sel;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          timeout_err;
    logic [1:0]    state;

    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_reg_write,
               ex_muldiv, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
               can_branch, branch_taken, jump, mem_req, mem_ready,
        input  stall_front, bubble_id_ex, flush_if_id, freeze_all, pc_sel,
               fwd_a, fwd_b, timeout_err, state
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_reg_write,
               ex_muldiv, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
               can_branch, branch_taken, jump, mem_req, mem_ready,
        output stall_front, bubble_id_ex, flush_if_id, freeze_all, pc_sel,
               fwd_a, fwd_b, timeout_err, state
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Forwarding select, RAW/load-use stall, control-flow flush and
//            multi-cycle / memory-wait freeze sequencing with timeout trap.
// Revision : 1.0
//==============================================================================
module pipeline_hazard_ctrl #(
    parameter int RW          = 5,
    parameter int MULDIV_LAT  = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int FWD_EN      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_MD_WAIT  = 2'b01,
        S_MEM_WAIT = 2'b10,
        S_TRAP     = 2'b11
    } state_t;

    localparam logic [RW-1:0] c_reg_zero = '0;

    state_t      r_state;
    logic [15:0] r_wait_cnt;
    logic [4:0]  r_md_cnt;
    logic        r_md_done;

    logic        w_mem_stall;
    logic        w_md_start;
    logic        w_id_match_ex;
    logic        w_id_match_mem;
    logic        w_raw_stall;
    logic        w_branch;
    logic        w_stall_front;
    logic        w_bubble_id_ex;
    logic        w_flush_if_id;
    logic        w_freeze_all;
    logic        w_timeout_err;
    logic [1:0]  w_pc_sel;

    function automatic logic [1:0] fwd_src(input logic [RW-1:0] rs,
                                           input logic          mem_w,
                                           input logic [RW-1:0] mem_rd,
                                           input logic          wb_w,
                                           input logic [RW-1:0] wb_rd);
        if (mem_w && mem_rd != c_reg_zero && mem_rd == rs) return 2'b10;
        if (wb_w && wb_rd != c_reg_zero && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    assign w_mem_stall    = bus.mem_req && !bus.mem_ready;
    // The multi-cycle op stays in EX after its wait; r_md_done keeps it from re-arming.
    assign w_md_start     = bus.ex_muldiv && !r_md_done;
    assign w_id_match_ex  = (bus.ex_rd != c_reg_zero) &&
                            (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
    assign w_id_match_mem = (bus.mem_rd != c_reg_zero) &&
                            (bus.mem_rd == bus.id_rs1 || bus.mem_rd == bus.id_rs2);
    assign w_raw_stall    = (bus.ex_mem_read && w_id_match_ex) ||
                            ((FWD_EN == 0) && ((bus.ex_reg_write && w_id_match_ex) ||
                                               (bus.mem_reg_write && w_id_match_mem)));
    assign w_branch       = bus.can_branch && bus.branch_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 16'd0;
            r_md_cnt   <= 5'd0;
            r_md_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_RUN: begin
                    if (w_mem_stall) begin
                        r_wait_cnt <= 16'd1;
                        r_state    <= (MEM_TIMEOUT <= 1) ? S_TRAP : S_MEM_WAIT;
                    end else if (w_md_start) begin
                        r_md_cnt  <= 5'd1;
                        r_md_done <= (MULDIV_LAT <= 2);
                        r_state   <= (MULDIV_LAT <= 2) ? S_RUN : S_MD_WAIT;
                    end else begin
                        r_md_done <= 1'b0;
                    end
                end
                S_MD_WAIT: begin
                    if (int'(r_md_cnt) + 1 >= MULDIV_LAT - 1) begin
                        r_state   <= S_RUN;
                        r_md_cnt  <= 5'd0;
                        r_md_done <= 1'b1;
                    end else begin
                        r_md_cnt <= r_md_cnt + 5'd1;
                    end
                end
                S_MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= 16'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                        if (int'(r_wait_cnt) + 1 >= MEM_TIMEOUT) r_state <= S_TRAP;
                    end
                end
                S_TRAP: begin
                    r_state    <= S_RUN;
                    r_wait_cnt <= 16'd0;
                    r_md_done  <= 1'b0;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    always_comb begin
        w_stall_front  = 1'b0;
        w_bubble_id_ex = 1'b0;
        w_flush_if_id  = 1'b0;
        w_freeze_all   = 1'b0;
        w_timeout_err  = 1'b0;
        w_pc_sel       = 2'b00;
        if (!rst) begin
            unique case (r_state)
                S_RUN: begin
                    if (w_mem_stall || w_md_start) begin
                        w_freeze_all  = 1'b1;
                        w_stall_front = 1'b1;
                    end else if (bus.jump || w_branch) begin
                        // Redirect squashes the wrong-path instruction, so no load-use stall.
                        w_pc_sel       = bus.jump ? 2'b10 : 2'b01;
                        w_flush_if_id  = 1'b1;
                        w_bubble_id_ex = 1'b1;
                    end else if (w_raw_stall) begin
                        w_stall_front  = 1'b1;
                        w_bubble_id_ex = 1'b1;
                    end
                end
                S_MD_WAIT: begin
                    w_freeze_all  = 1'b1;
                    w_stall_front = 1'b1;
                end
                S_MEM_WAIT: begin
                    w_freeze_all  = !bus.mem_ready;
                    w_stall_front = !bus.mem_ready;
                end
                S_TRAP: begin
                    w_timeout_err  = 1'b1;
                    w_pc_sel       = 2'b11;
                    w_flush_if_id  = 1'b1;
                    w_bubble_id_ex = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.stall_front  = w_stall_front;
    assign bus.bubble_id_ex = w_bubble_id_ex;
    assign bus.flush_if_id  = w_flush_if_id;
    assign bus.freeze_all   = w_freeze_all;
    assign bus.timeout_err  = w_timeout_err;
    assign bus.pc_sel       = w_pc_sel;
    assign bus.state        = r_state;
    assign bus.fwd_a = (rst || FWD_EN == 0) ? 2'b00 :
                       fwd_src(bus.ex_rs1, bus.mem_reg_write, bus.mem_rd, bus.wb_reg_write, bus.wb_rd);
    assign bus.fwd_b = (rst || FWD_EN == 0) ? 2'b00 :
                       fwd_src(bus.ex_rs2, bus.mem_reg_write, bus.mem_rd, bus.wb_reg_write, bus.wb_rd);

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Self-checking bench: forwarding and stalling DUT variants against a
//            rule-level reference model plus directed wait/trap/reset scenarios.
// Revision : 1.0
//==============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int TB_LAT = 4;
    localparam int TB_TO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.RW(5)) bus_f ();
    pipeline_hazard_ctrl_if #(.RW(5)) bus_s ();

    pipeline_hazard_ctrl #(.RW(5), .MULDIV_LAT(TB_LAT), .MEM_TIMEOUT(TB_TO), .FWD_EN(1))
        dut_f (.clk(clk), .rst(rst), .bus(bus_f));
    pipeline_hazard_ctrl #(.RW(5), .MULDIV_LAT(TB_LAT), .MEM_TIMEOUT(TB_TO), .FWD_EN(0))
        dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    assign bus_s.id_rs1        = bus_f.id_rs1;
    assign bus_s.id_rs2        = bus_f.id_rs2;
    assign bus_s.ex_rs1        = bus_f.ex_rs1;
    assign bus_s.ex_rs2        = bus_f.ex_rs2;
    assign bus_s.ex_rd         = bus_f.ex_rd;
    assign bus_s.ex_mem_read   = bus_f.ex_mem_read;
    assign bus_s.ex_reg_write  = bus_f.ex_reg_write;
    assign bus_s.ex_muldiv     = bus_f.ex_muldiv;
    assign bus_s.mem_rd        = bus_f.mem_rd;
    assign bus_s.mem_reg_write = bus_f.mem_reg_write;
    assign bus_s.wb_rd         = bus_f.wb_rd;
    assign bus_s.wb_reg_write  = bus_f.wb_reg_write;
    assign bus_s.can_branch    = bus_f.can_branch;
    assign bus_s.branch_taken  = bus_f.branch_taken;
    assign bus_s.jump          = bus_f.jump;
    assign bus_s.mem_req       = bus_f.mem_req;
    assign bus_s.mem_ready     = bus_f.mem_ready;

    // Vector layout: stall, bubble, flush, freeze, timeout, pc_sel, fwd_a, fwd_b, state
    function automatic logic [12:0] act_f();
        return {bus_f.stall_front, bus_f.bubble_id_ex, bus_f.flush_if_id, bus_f.freeze_all,
                bus_f.timeout_err, bus_f.pc_sel, bus_f.fwd_a, bus_f.fwd_b, bus_f.state};
    endfunction

    function automatic logic [12:0] act_s();
        return {bus_s.stall_front, bus_s.bubble_id_ex, bus_s.flush_if_id, bus_s.freeze_all,
                bus_s.timeout_err, bus_s.pc_sel, bus_s.fwd_a, bus_s.fwd_b, bus_s.state};
    endfunction

    function automatic logic [12:0] vec(input bit stall, input bit bub, input bit fl,
                                        input bit frz, input bit te, input logic [1:0] pc,
                                        input logic [1:0] st);
        return {stall, bub, fl, frz, te, pc, 2'b00, 2'b00, st};
    endfunction

    function automatic logic [1:0] ref_src(input logic [4:0] rs);
        if (bus_f.mem_reg_write && bus_f.mem_rd != 0 && bus_f.mem_rd == rs) return 2'b10;
        if (bus_f.wb_reg_write && bus_f.wb_rd != 0 && bus_f.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Expected outputs in RUN with no memory wait and no multi-cycle op pending.
    function automatic logic [12:0] model_run(input bit fwd_en);
        bit         hit_ex, hit_mem, hazard, stall, bub, fl;
        logic [1:0] pc, fa, fb;
        hit_ex  = bus_f.ex_rd != 0 && (bus_f.ex_rd == bus_f.id_rs1 || bus_f.ex_rd == bus_f.id_rs2);
        hit_mem = bus_f.mem_rd != 0 && (bus_f.mem_rd == bus_f.id_rs1 || bus_f.mem_rd == bus_f.id_rs2);
        hazard  = (bus_f.ex_mem_read && hit_ex) ||
                  (!fwd_en && ((bus_f.ex_reg_write && hit_ex) || (bus_f.mem_reg_write && hit_mem)));
        fa = fwd_en ? ref_src(bus_f.ex_rs1) : 2'b00;
        fb = fwd_en ? ref_src(bus_f.ex_rs2) : 2'b00;
        stall = 0; bub = 0; fl = 0; pc = 2'b00;
        if (bus_f.jump) begin pc = 2'b10; fl = 1; bub = 1; end
        else if (bus_f.can_branch && bus_f.branch_taken) begin pc = 2'b01; fl = 1; bub = 1; end
        else if (hazard) begin stall = 1; bub = 1; end
        return {stall, bub, fl, 1'b0, 1'b0, pc, fa, fb, 2'b00};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_f.id_rs1 = 0; bus_f.id_rs2 = 0; bus_f.ex_rs1 = 0; bus_f.ex_rs2 = 0; bus_f.ex_rd = 0;
        bus_f.ex_mem_read = 0; bus_f.ex_reg_write = 0; bus_f.ex_muldiv = 0;
        bus_f.mem_rd = 0; bus_f.mem_reg_write = 0; bus_f.wb_rd = 0; bus_f.wb_reg_write = 0;
        bus_f.can_branch = 0; bus_f.branch_taken = 0; bus_f.jump = 0;
        bus_f.mem_req = 0; bus_f.mem_ready = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus_f.jump = 1; bus_f.mem_req = 1; bus_f.ex_muldiv = 1;
        bus_f.mem_rd = 3; bus_f.mem_reg_write = 1; bus_f.ex_rs1 = 3; bus_f.ex_rs2 = 3;
        #3;
        n_vec++;
        if (act_f() !== 13'd0) begin n_err++; $display("FAIL reset_f: got %h expected %h", act_f(), 13'd0); end
        n_vec++;
        if (act_s() !== 13'd0) begin n_err++; $display("FAIL reset_s: got %h expected %h", act_s(), 13'd0); end
        next_cycle();
        clear_inputs();
        rst = 0;
        #2;
        n_vec++;
        if (act_f() !== 13'd0) begin n_err++; $display("FAIL reset_release: got %h expected %h", act_f(), 13'd0); end
    endtask

    task automatic test_load_use();
        next_cycle(); clear_inputs();
        bus_f.ex_mem_read = 1; bus_f.ex_rd = 5; bus_f.id_rs2 = 5;
        #2;
        n_vec++;
        if (act_f() !== vec(1, 1, 0, 0, 0, 2'b00, 2'b00)) begin
            n_err++; $display("FAIL load_use_hit: got %h expected %h", act_f(), vec(1, 1, 0, 0, 0, 2'b00, 2'b00));
        end
        next_cycle(); clear_inputs();
        #2;
        n_vec++;
        if (act_f() !== 13'd0) begin n_err++; $display("FAIL load_use_one_cycle: got %h expected %h", act_f(), 13'd0); end
        next_cycle(); clear_inputs();
        bus_f.ex_mem_read = 1; bus_f.ex_rd = 0; bus_f.id_rs2 = 0;
        #2;
        n_vec++;
        if (act_f() !== 13'd0) begin n_err++; $display("FAIL load_use_rd0: got %h expected %h", act_f(), 13'd0); end
    endtask

    task automatic test_forwarding();
        next_cycle(); clear_inputs();
        bus_f.mem_rd = 3; bus_f.mem_reg_write = 1; bus_f.wb_rd = 3; bus_f.wb_reg_write = 1; bus_f.ex_rs1 = 3;
        #2;
        n_vec++;
        if (bus_f.fwd_a !== 2'b10) begin n_err++; $display("FAIL fwd_mem_priority: got %b expected 10", bus_f.fwd_a); end
        n_vec++;
        if (bus_s.fwd_a !== 2'b00) begin n_err++; $display("FAIL fwd_disabled: got %b expected 00", bus_s.fwd_a); end
        next_cycle();
        bus_f.mem_reg_write = 0;
        #2;
        n_vec++;
        if (bus_f.fwd_a !== 2'b01) begin n_err++; $display("FAIL fwd_wb: got %b expected 01", bus_f.fwd_a); end
        next_cycle();
        bus_f.mem_reg_write = 1; bus_f.id_rs1 = 3;
        #2;
        n_vec++;
        if ({bus_s.stall_front, bus_s.bubble_id_ex, bus_s.fwd_a} !== 4'b1100) begin
            n_err++; $display("FAIL raw_stall_nofwd: got %b expected 1100",
                              {bus_s.stall_front, bus_s.bubble_id_ex, bus_s.fwd_a});
        end
        n_vec++;
        if ({bus_f.stall_front, bus_f.fwd_a} !== 3'b010) begin
            n_err++; $display("FAIL raw_fwd_nostall: got %b expected 010", {bus_f.stall_front, bus_f.fwd_a});
        end
    endtask

    task automatic test_random_run(input int n);
        logic [12:0] e;
        for (int i = 0; i < n; i++) begin
            next_cycle(); clear_inputs();
            bus_f.id_rs1 = 5'($urandom_range(0, 3));
            bus_f.id_rs2 = 5'($urandom_range(0, 3));
            bus_f.ex_rs1 = 5'($urandom_range(0, 3));
            bus_f.ex_rs2 = 5'($urandom_range(0, 3));
            bus_f.ex_rd  = 5'($urandom_range(0, 3));
            bus_f.mem_rd = 5'($urandom_range(0, 3));
            bus_f.wb_rd  = 5'($urandom_range(0, 3));
            bus_f.ex_mem_read   = 1'($urandom_range(0, 1));
            bus_f.ex_reg_write  = 1'($urandom_range(0, 1));
            bus_f.mem_reg_write = 1'($urandom_range(0, 1));
            bus_f.wb_reg_write  = 1'($urandom_range(0, 1));
            bus_f.jump          = ($urandom_range(0, 7) == 0);
            bus_f.can_branch    = 1'($urandom_range(0, 1));
            bus_f.branch_taken  = ($urandom_range(0, 3) == 0);
            bus_f.mem_req       = 1'($urandom_range(0, 1));
            bus_f.mem_ready     = 1'b1;
            #2;
            e = model_run(1'b1);
            n_vec++;
            if (act_f() !== e) begin n_err++; $display("FAIL random_fwd[%0d]: got %h expected %h", i, act_f(), e); end
            e = model_run(1'b0);
            n_vec++;
            if (act_s() !== e) begin n_err++; $display("FAIL random_stall[%0d]: got %h expected %h", i, act_s(), e); end
        end
    endtask

    task automatic test_jump_priority();
        next_cycle(); clear_inputs();
        bus_f.jump = 1; bus_f.ex_mem_read = 1; bus_f.ex_rd = 5; bus_f.id_rs1 = 5;
        #2;
        n_vec++;
        if (act_f() !== vec(0, 1, 1, 0, 0, 2'b10, 2'b00)) begin
            n_err++; $display("FAIL jump_over_load_use: got %h expected %h", act_f(), vec(0, 1, 1, 0, 0, 2'b10, 2'b00));
        end
        next_cycle();
        bus_f.jump = 0; bus_f.can_branch = 1; bus_f.branch_taken = 1;
        #2;
        n_vec++;
        if (act_f() !== vec(0, 1, 1, 0, 0, 2'b01, 2'b00)) begin
            n_err++; $display("FAIL branch_over_load_use: got %h expected %h", act_f(), vec(0, 1, 1, 0, 0, 2'b01, 2'b00));
        end
    endtask

    task automatic test_muldiv();
        logic [12:0] e;
        bit          frz;
        for (int c = 0; c < 6; c++) begin
            next_cycle(); clear_inputs();
            bus_f.ex_muldiv = (c < TB_LAT);
            #2;
            frz = (c < TB_LAT - 1);
            e   = vec(frz, 0, 0, frz, 0, 2'b00, (c >= 1 && c < TB_LAT - 1) ? 2'b01 : 2'b00);
            n_vec++;
            if (act_f() !== e) begin n_err++; $display("FAIL muldiv[%0d]: got %h expected %h", c, act_f(), e); end
        end
    endtask

    // Memory access with ready first seen on cycle r; br drives a taken branch while frozen.
    task automatic test_mem_wait(input int r, input bit br);
        logic [12:0] e;
        bit          resolved = 0;
        bit          trap_next = 0;
        int          waited = 0;
        for (int t = 1; t <= 12; t++) begin
            next_cycle(); clear_inputs();
            if (trap_next) begin
                bus_f.mem_req = 1;
                e = vec(0, 1, 1, 0, 1, 2'b11, 2'b11);
                trap_next = 0;
                resolved  = 1;
            end else if (resolved) begin
                e = 13'd0;
            end else begin
                bus_f.mem_req   = 1;
                bus_f.mem_ready = (t >= r);
                if (bus_f.mem_ready) begin
                    e = vec(0, 0, 0, 0, 0, 2'b00, (t == 1) ? 2'b00 : 2'b10);
                    resolved = 1;
                end else begin
                    bus_f.can_branch = br; bus_f.branch_taken = br;
                    waited++;
                    e = vec(1, 0, 0, 1, 0, 2'b00, (t == 1) ? 2'b00 : 2'b10);
                    if (waited == TB_TO) trap_next = 1;
                end
            end
            #2;
            n_vec++;
            if (act_f() !== e) begin n_err++; $display("FAIL mem_wait r=%0d t=%0d: got %h expected %h", r, t, act_f(), e); end
        end
    endtask

    task automatic test_mem_then_muldiv();
        bit          frz [8] = '{1, 1, 0, 1, 1, 1, 0, 0};
        logic [1:0]  st  [8] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        logic [12:0] e;
        for (int c = 0; c < 8; c++) begin
            next_cycle(); clear_inputs();
            bus_f.mem_req   = (c < 3);
            bus_f.mem_ready = (c == 2);
            bus_f.ex_muldiv = (c < 7);
            #2;
            e = vec(frz[c], 0, 0, frz[c], 0, 2'b00, st[c]);
            n_vec++;
            if (act_f() !== e) begin n_err++; $display("FAIL mem_then_muldiv[%0d]: got %h expected %h", c, act_f(), e); end
        end
    endtask

    task automatic test_reset_mid_wait(input bit md);
        logic [12:0] e;
        int          n = md ? 2 : 4;
        for (int t = 1; t <= n; t++) begin
            next_cycle(); clear_inputs();
            bus_f.mem_req = !md; bus_f.ex_muldiv = md;
        end
        #2;
        e = vec(1, 0, 0, 1, 0, 2'b00, md ? 2'b01 : 2'b10);
        n_vec++;
        if (act_f() !== e) begin n_err++; $display("FAIL pre_reset_wait md=%0d: got %h expected %h", md, act_f(), e); end
        rst = 1;
        #1;
        n_vec++;
        if (act_f() !== 13'd0) begin n_err++; $display("FAIL reset_mid_wait md=%0d: got %h expected %h", md, act_f(), 13'd0); end
        next_cycle();
        next_cycle();
        rst = 0; clear_inputs();
        for (int t = 0; t < 10; t++) begin
            #2;
            n_vec++;
            if (act_f() !== 13'd0) begin n_err++; $display("FAIL post_reset md=%0d t=%0d: got %h expected %h", md, t, act_f(), 13'd0); end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_random_run(80);
        test_jump_priority();
        test_muldiv();
        test_mem_wait(3, 1'b0);
        test_mem_wait(99, 1'b1);
        test_mem_wait(1, 1'b0);
        test_mem_wait(TB_TO, 1'b1);
        test_mem_wait(TB_TO + 1, 1'b0);
        test_mem_wait(int'($urandom_range(2, 11)), 1'b1);
        test_mem_then_muldiv();
        test_reset_mid_wait(1'b0);
        test_reset_mid_wait(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
